// File: rtl/mc_ctrl_wait.sv
// Multicycle MIPS control unit with variable-latency memory handshake,
// a sticky wait-timeout monitor and a parametrised ALU-control width.
// Optional feature macro: MC_CTRL_TRAP_EN. When it is defined, an illegal
// opcode/funct or a memory timeout takes a one-cycle TRAP state.
module mc_ctrl_wait #(
  parameter int unsigned ALUCTL_W     = 3,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [5:0]          Op,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemToReg,
  output logic                ALUSrcA,
  output logic                PCEn,
  output logic                ExtOp,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUCTL_W-1:0] ALUCtl,
  output logic                Timeout,
  output logic                Exc,
  output logic [3:0]          StateDbg
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEX    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JEX    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

`ifdef MC_CTRL_TRAP_EN
  localparam state_t S_ILLEGAL = S_TRAP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic                waiting_c;
  logic                wait_hit_c;
  logic [ALUCTL_W-1:0] rex_alu_c;
  logic                rex_ok_c;

  // A wait cycle is any memory-state cycle without MemReady; the hit fires
  // on the cycle whose edge would bring the counter up to WAIT_TIMEOUT.
  assign waiting_c  = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR)) && !MemReady;
  assign wait_hit_c = waiting_c && (wait_q == WAIT_LAST);

  // Wait counter and sticky timeout flag next-state.
  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q | wait_hit_c;
    if (waiting_c && (state_d == state_q)) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  // R-type funct decode for the execute step.
  always_comb begin
    rex_alu_c = ALU_ADD;
    rex_ok_c  = 1'b1;
    case (Funct)
      6'b100000: rex_alu_c = ALU_ADD;
      6'b100010: rex_alu_c = ALU_SUB;
      6'b100100: rex_alu_c = ALU_AND;
      6'b100101: rex_alu_c = ALU_OR;
      6'b101010: rex_alu_c = ALU_SLT;
      default:   rex_ok_c  = 1'b0;
    endcase
  end

  // State, wait counter and timeout registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and Moore control decode, gated by MemReady/Zero where needed.
  always_comb begin
    state_d  = state_q;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    PCEn     = 1'b0;
    ExtOp    = 1'b1;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUCtl   = ALU_ADD;
    Exc      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:                         state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                       state_d = S_BEX;
          OP_J:                                 state_d = S_JEX;
          OP_RTYPE:                             state_d = S_REX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:    state_d = S_IEX;
          default:                              state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUCtl  = rex_alu_c;
        state_d = rex_ok_c ? S_RWB : S_ILLEGAL;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEX: begin
        // Operand A is the rs register, as for every other ALU op on registers.
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (Op)
          OP_ANDI: begin ALUCtl = ALU_AND; ExtOp = 1'b0; end
          OP_ORI:  begin ALUCtl = ALU_OR;  ExtOp = 1'b0; end
          OP_SLTI: ALUCtl = ALU_SLT;
          default: ALUCtl = ALU_ADD;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEX: begin
        // Op[0] distinguishes bne from beq, so it inverts the taken sense.
        ALUSrcA = 1'b1;
        ALUCtl  = ALU_SUB;
        PCSrc   = 2'b01;
        PCEn    = Zero ^ Op[0];
        state_d = S_FETCH;
      end
      S_JEX: begin
        PCSrc   = 2'b10;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
        Exc   = 1'b1;
        PCSrc = 2'b11;
        PCEn  = 1'b1;
`endif
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
`ifdef MC_CTRL_TRAP_EN
    if (wait_hit_c) state_d = S_TRAP;
`endif
  end

  assign Timeout  = timeout_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_wait.sv
// Self-checking bench for mc_ctrl_wait: directed vector table, hand-written
// multi-cycle wait/timeout/reset sequences and an instruction-level random
// reference model.
module tb_mc_ctrl_wait;

  localparam int unsigned ALUCTL_W     = 3;
  localparam int unsigned WAIT_TIMEOUT = 15;
`ifdef MC_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000,
                         A_OR = 3'b001, A_SLT = 3'b111;

  logic CLK = 1'b0;
  logic Reset, Zero, MemReady;
  logic [5:0] Op, Funct;
  logic MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA;
  logic PCEn, ExtOp, Timeout, Exc;
  logic [1:0] ALUSrcB, PCSrc;
  logic [ALUCTL_W-1:0] ALUCtl;
  logic [3:0] StateDbg;
  logic [18:0] dut_vec;

  int n_pass  = 0;
  int n_total = 0;

  mc_ctrl_wait #(.ALUCTL_W(ALUCTL_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .PCEn(PCEn), .ExtOp(ExtOp),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtl(ALUCtl), .Timeout(Timeout),
    .Exc(Exc), .StateDbg(StateDbg)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemToReg,
                    ALUSrcA, PCEn, ExtOp, ALUSrcB, PCSrc, ALUCtl, Timeout, Exc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] f,
                       input logic z, input logic rdy);
    Reset = r; Op = op; Funct = f; Zero = z; MemReady = rdy;
    #2;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Expected control word for a state, written from the per-state control list.
  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] op,
      input logic [5:0] f, input logic z, input logic rdy, input logic to);
    logic mr, mw, iord, irw, rw, rd, m2r, asa, pce, ext, exc;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    mr = 0; mw = 0; iord = 0; irw = 0; rw = 0; rd = 0; m2r = 0; asa = 0;
    pce = 0; ext = 1; exc = 0; asb = 2'd0; pcs = 2'd0; alu = A_ADD;
    case (st)
      0:  begin mr = 1; asb = 2'd1; irw = rdy; pce = rdy; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin iord = 1; mr = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
            asa = 1;
            if (f == 6'h20) alu = A_ADD;
            else if (f == 6'h22) alu = A_SUB;
            else if (f == 6'h24) alu = A_AND;
            else if (f == 6'h25) alu = A_OR;
            else if (f == 6'h2A) alu = A_SLT;
          end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = A_SUB; pcs = 2'd1; pce = (op == 6'h04) ? z : !z; end
      9:  begin
            asa = 1; asb = 2'd2;
            if (op == 6'h0C) begin alu = A_AND; ext = 0; end
            else if (op == 6'h0D) begin alu = A_OR; ext = 0; end
            else if (op == 6'h0A) alu = A_SLT;
          end
      10: rw = 1;
      11: begin pcs = 2'd2; pce = 1; end
      12: begin exc = 1; pcs = 2'd3; pce = 1; end
      default: ;
    endcase
    return {mr, mw, iord, irw, rw, rd, m2r, asa, pce, ext, asb, pcs, alu, to, exc};
  endfunction

  // Instruction-level model: the ordered list of states one instruction visits.
  int ph[8];
  int ph_len;
  task automatic build(input logic [5:0] op, input logic [5:0] f);
    bit illegal;
    illegal = 0;
    ph[0] = 0; ph[1] = 1; ph_len = 2;
    case (op)
      6'h23: begin ph[2] = 2; ph[3] = 3; ph[4] = 4; ph_len = 5; end
      6'h2B: begin ph[2] = 2; ph[3] = 5; ph_len = 4; end
      6'h04, 6'h05: begin ph[2] = 8; ph_len = 3; end
      6'h02: begin ph[2] = 11; ph_len = 3; end
      6'h08, 6'h0C, 6'h0D, 6'h0A: begin ph[2] = 9; ph[3] = 10; ph_len = 4; end
      6'h00: begin
        ph[2] = 6; ph_len = 3;
        if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) begin
          ph[3] = 7; ph_len = 4;
        end else illegal = 1;
      end
      default: illegal = 1;
    endcase
    if (illegal && TRAP_EN) begin ph[ph_len] = 12; ph_len++; end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] f;
    logic       z;
    logic       rdy;
    int         st;
    logic [2:0] alu;
    logic       pcen, rw, rd, ext, irw;
  } vec_t;
  vec_t tbl[$];

  task automatic fd(input logic [5:0] op, input logic [5:0] f, input logic z);
    tbl.push_back('{op, f, z, 1'b1, 0, A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{op, f, z, 1'b1, 1, A_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask
  task automatic add_r(input logic [5:0] f, input logic [2:0] alu);
    fd(6'h00, f, 1'b0);
    tbl.push_back('{6'h00, f, 1'b0, 1'b1, 6, alu,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{6'h00, f, 1'b0, 1'b1, 7, A_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
  endtask
  task automatic add_br(input logic [5:0] op, input logic z, input logic pce);
    fd(op, 6'h00, z);
    tbl.push_back('{op, 6'h00, z, 1'b1, 8, A_SUB, pce, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask
  task automatic add_i(input logic [5:0] op, input logic [2:0] alu, input logic ext);
    fd(op, 6'h00, 1'b0);
    tbl.push_back('{op, 6'h00, 1'b0, 1'b1, 9,  alu,   1'b0, 1'b0, 1'b0, ext,  1'b0});
    tbl.push_back('{op, 6'h00, 1'b0, 1'b1, 10, A_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [5:0] op, f;
    logic z, rdy;
    int idx, run, st;
    logic [5:0] ops[12];
    logic [5:0] fns[6];

    // Reset state
    drive(1, 6'h00, 6'h00, 0, 0);
    adv(); adv();
    drive(0, 6'h00, 6'h00, 0, 0);
    chk("rst_state", 32'(StateDbg), 32'd0);
    chk("rst_ctl", 32'(dut_vec), 32'({1'b1, 8'b0, 1'b1, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0}));

    // Directed table: R-type, branches, immediates, jump with MemReady tied 1
    add_r(6'h20, A_ADD); add_r(6'h22, A_SUB); add_r(6'h24, A_AND);
    add_r(6'h25, A_OR);  add_r(6'h2A, A_SLT);
    add_br(6'h05, 0, 1); add_br(6'h05, 1, 0); add_br(6'h04, 1, 1); add_br(6'h04, 0, 0);
    add_i(6'h0C, A_AND, 0); add_i(6'h0A, A_SLT, 1); add_i(6'h08, A_ADD, 1);
    add_i(6'h0D, A_OR, 0);
    fd(6'h02, 6'h00, 0);
    tbl.push_back('{6'h02, 6'h00, 1'b0, 1'b1, 11, A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, tbl[i].op, tbl[i].f, tbl[i].z, tbl[i].rdy);
      chk("tbl_state", 32'(StateDbg), 32'(tbl[i].st));
      chk("tbl_aluctl", 32'(ALUCtl), 32'(tbl[i].alu));
      chk("tbl_pcen", 32'(PCEn), 32'(tbl[i].pcen));
      chk("tbl_regwrite", 32'(RegWrite), 32'(tbl[i].rw));
      chk("tbl_regdst", 32'(RegDst), 32'(tbl[i].rd));
      chk("tbl_extop", 32'(ExtOp), 32'(tbl[i].ext));
      chk("tbl_irwrite", 32'(IRWrite), 32'(tbl[i].irw));
      adv();
    end

    // lw with three MemReady-low cycles in MEMRD
    drive(0, 6'h23, 6'h00, 0, 1); chk("lw_fetch", 32'(StateDbg), 32'd0); adv();
    drive(0, 6'h23, 6'h00, 0, 1); adv();
    drive(0, 6'h23, 6'h00, 0, 1); chk("lw_memadr", 32'(StateDbg), 32'd2); adv();
    for (int i = 0; i < 4; i++) begin
      drive(0, 6'h23, 6'h00, 0, (i == 3));
      chk("lw_memrd_state", 32'(StateDbg), 32'd3);
      chk("lw_memrd_irw", 32'(IRWrite), 32'd0);
      chk("lw_memrd_read", 32'({MemRead, IorD}), 32'd3);
      adv();
    end
    drive(0, 6'h23, 6'h00, 0, 1);
    chk("lw_memwb_state", 32'(StateDbg), 32'd4);
    chk("lw_memwb_ctl", 32'({RegWrite, MemToReg, RegDst, IRWrite}), 32'b1100);
    adv();
    chk("lw_back_fetch", 32'(StateDbg), 32'd0);

    // MemReady stuck low in FETCH until the timeout
    drive(1, 6'h00, 6'h20, 0, 0); adv();
    drive(0, 6'h00, 6'h20, 0, 0);
    for (int i = 0; i < 14; i++) adv();
    chk("to_before_flag", 32'(Timeout), 32'd0);
    chk("to_before_state", 32'(StateDbg), 32'd0);
    adv();
    chk("to_flag", 32'(Timeout), 32'd1);
    if (TRAP_EN) begin
      chk("to_trap_state", 32'(StateDbg), 32'd12);
      chk("to_trap_ctl", 32'({Exc, PCSrc, PCEn}), 32'b1111);
      adv();
      chk("to_trap_exit", 32'(StateDbg), 32'd0);
    end else begin
      chk("to_hold_state", 32'(StateDbg), 32'd0);
      chk("to_exc_low", 32'(Exc), 32'd0);
    end
    drive(0, 6'h00, 6'h20, 0, 1); adv();
    chk("to_sticky_state", 32'(StateDbg), 32'd1);
    chk("to_sticky_flag", 32'(Timeout), 32'd1);

    // MemReady arrives on the cycle the counter would reach the limit
    drive(1, 6'h00, 6'h20, 0, 0); adv();
    chk("sim_rst_flag", 32'(Timeout), 32'd0);
    drive(0, 6'h00, 6'h20, 0, 0);
    for (int i = 0; i < 14; i++) adv();
    drive(0, 6'h00, 6'h20, 0, 1); adv();
    chk("sim_state", 32'(StateDbg), 32'd1);
    chk("sim_flag", 32'(Timeout), 32'd0);

    // Reset pulsed during a MEMWR wait
    drive(1, 6'h2B, 6'h00, 0, 0); adv();
    drive(0, 6'h2B, 6'h00, 0, 1); adv(); adv(); adv();
    drive(0, 6'h2B, 6'h00, 0, 0);
    chk("sw_memwr_state", 32'(StateDbg), 32'd5);
    chk("sw_memwr_write", 32'(MemWrite), 32'd1);
    for (int i = 0; i < 10; i++) adv();
    drive(1, 6'h2B, 6'h00, 0, 0); adv();
    drive(0, 6'h2B, 6'h00, 0, 0);
    chk("rstw_state", 32'(StateDbg), 32'd0);
    chk("rstw_memwrite", 32'(MemWrite), 32'd0);
    chk("rstw_flag", 32'(Timeout), 32'd0);
    for (int i = 0; i < 14; i++) adv();
    chk("rstw_counter_cleared", 32'(Timeout), 32'd0);
    adv();
    chk("rstw_counter_full", 32'(Timeout), 32'd1);

    // Random instruction stream against the instruction-level model
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A,
            6'h3F, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    drive(1, 6'h00, 6'h20, 0, 0); adv();
    idx = 0; run = 0; ph_len = 0; op = 6'h00; f = 6'h20;
    for (int c = 0; c < 3000; c++) begin
      if (idx >= ph_len) begin
        op = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        f = fns[$urandom_range(0, 5)];
        if (f == 6'h00) f = 6'($urandom);
        build(op, f);
        idx = 0;
      end
      st  = ph[idx];
      rdy = ($urandom_range(0, 3) != 0) || (run >= 4);
      z   = 1'($urandom_range(0, 1));
      drive(0, op, f, z, rdy);
      chk("rnd_state", 32'(StateDbg), 32'(st));
      chk("rnd_ctl", 32'(dut_vec), 32'(exp_vec(st, op, f, z, rdy, 1'b0)));
      if ((st == 0 || st == 3 || st == 5) && !rdy) run++;
      else begin run = 0; idx++; end
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
